// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : watch_pkg
// Description : Mode encoding shared by the watch input front-end and the
//               time counter block.
// Revision    : 1.0 - initial release
// ============================================================================
package watch_pkg;

    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_SEC  = 2'b01;
    localparam logic [1:0] MODE_SET_MIN  = 2'b10;
    localparam logic [1:0] MODE_SET_HOUR = 2'b11;

    function automatic logic [1:0] mode_advance(input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = MODE_RUN;
        case (cur)
            MODE_RUN:      nxt = MODE_SET_SEC;
            MODE_SET_SEC:  nxt = MODE_SET_MIN;
            MODE_SET_MIN:  nxt = MODE_SET_HOUR;
            MODE_SET_HOUR: nxt = MODE_RUN;
            default:       nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Synchronizer chain plus stable-count debouncer for one raw
//               button; emits the clean level and a registered press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_press;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], btn};
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (w_synced == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/watch_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : watch_input_ctrl
// Description : Button front-end for the watch: mode FSM with idle timeout,
//               gated plus/minus pulses with hold-to-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module watch_input_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_RATE     = 5_000_000,
    parameter int IDLE_TIMEOUT    = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_plus,
    input  logic       btn_minus,
    output logic [1:0] mode,
    output logic       enable,
    output logic       plus,
    output logic       minus
);

    import watch_pkg::*;

    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_REP_W   = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
    localparam int c_IDLE_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [c_REP_W-1:0]  c_REP_DELAY_M1 = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0]  c_REP_RATE_M1  = c_REP_W'(REPEAT_RATE - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_M1      = c_IDLE_W'(IDLE_TIMEOUT - 1);

    logic w_lvl_mode, w_lvl_plus, w_lvl_minus;
    logic w_press_mode, w_press_plus, w_press_minus;

    button_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .level(w_lvl_mode), .press(w_press_mode));
    button_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_plus (
        .clk(clk), .reset(reset), .btn(btn_plus), .level(w_lvl_plus), .press(w_press_plus));
    button_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_minus (
        .clk(clk), .reset(reset), .btn(btn_minus), .level(w_lvl_minus), .press(w_press_minus));

    logic [1:0]          r_mode, w_mode_nxt;
    logic                r_enable;
    logic [c_IDLE_W-1:0] r_idle_cnt, w_idle_nxt;
    logic                r_rep_active, w_rep_active_nxt;
    logic                r_rep_dir, w_rep_dir_nxt;      // 0 = plus, 1 = minus
    logic                r_rep_first, w_rep_first_nxt;
    logic [c_REP_W-1:0]  r_rep_cnt, w_rep_cnt_nxt;

    logic w_set, w_both, w_rep_held, w_rep_fire, w_pulse_ok, w_timeout;
    logic [c_REP_W-1:0] w_rep_limit;

    always_comb begin
        w_set       = (r_mode != MODE_RUN);
        w_both      = w_lvl_plus & w_lvl_minus;
        w_rep_held  = r_rep_dir ? w_lvl_minus : w_lvl_plus;
        w_rep_limit = r_rep_first ? c_REP_DELAY_M1 : c_REP_RATE_M1;
        w_rep_fire  = r_rep_active & w_rep_held & (r_rep_cnt == w_rep_limit);
        // A simultaneous mode press wins over any plus/minus pulse.
        w_pulse_ok  = w_set & ~w_both & ~w_press_mode;
        w_timeout   = w_set & (r_idle_cnt == c_IDLE_M1);
        plus        = w_pulse_ok & (w_press_plus  | (w_rep_fire & ~r_rep_dir));
        minus       = w_pulse_ok & (w_press_minus | (w_rep_fire &  r_rep_dir));
    end

    // Next-state: mode and idle timer
    always_comb begin
        w_mode_nxt = r_mode;
        w_idle_nxt = '0;
        if (w_press_mode) begin
            w_mode_nxt = mode_advance(r_mode);
        end else if (w_timeout) begin
            w_mode_nxt = MODE_RUN;
        end else if (w_set && !(w_lvl_mode || w_lvl_plus || w_lvl_minus ||
                                w_press_plus || w_press_minus)) begin
            w_idle_nxt = r_idle_cnt + 1'b1;
        end
    end

    // Next-state: repeat engine; only a fresh press can arm it
    always_comb begin
        w_rep_active_nxt = 1'b0;
        w_rep_dir_nxt    = r_rep_dir;
        w_rep_first_nxt  = r_rep_first;
        w_rep_cnt_nxt    = '0;
        if (!w_pulse_ok) begin
            w_rep_active_nxt = 1'b0;
        end else if (w_press_plus || w_press_minus) begin
            w_rep_active_nxt = 1'b1;
            w_rep_dir_nxt    = w_press_minus;
            w_rep_first_nxt  = 1'b1;
        end else if (r_rep_active && w_rep_held) begin
            w_rep_active_nxt = 1'b1;
            if (w_rep_fire) begin
                w_rep_first_nxt = 1'b0;
            end else begin
                w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode       <= MODE_RUN;
            r_enable     <= 1'b1;
            r_idle_cnt   <= '0;
            r_rep_active <= 1'b0;
            r_rep_dir    <= 1'b0;
            r_rep_first  <= 1'b0;
            r_rep_cnt    <= '0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_enable     <= (w_mode_nxt == MODE_RUN);
            r_idle_cnt   <= w_idle_nxt;
            r_rep_active <= w_rep_active_nxt;
            r_rep_dir    <= w_rep_dir_nxt;
            r_rep_first  <= w_rep_first_nxt;
            r_rep_cnt    <= w_rep_cnt_nxt;
        end
    end

    assign mode   = r_mode;
    assign enable = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_watch_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_watch_input_ctrl
// Description : Directed self-checking bench for watch_input_ctrl with short
//               debounce/repeat/timeout parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_watch_input_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_plus, btn_minus;
    logic [1:0] mode;
    logic       enable, plus, minus;

    int n_pass  = 0;
    int n_total = 0;

    watch_input_ctrl #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20),
        .REPEAT_RATE(5), .IDLE_TIMEOUT(100)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_plus(btn_plus),
        .btn_minus(btn_minus), .mode(mode), .enable(enable), .plus(plus), .minus(minus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode_btn(input int hold);
        btn_mode = 1'b1;
        repeat (hold) tick();
        btn_mode = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_mode = 1'b0; btn_plus = 1'b0; btn_minus = 1'b0;
        repeat (3) tick();
        n_total++; if (mode !== 2'b00) $display("FAIL reset_mode: got %0b want 00", mode); else n_pass++;
        n_total++; if (enable !== 1'b1) $display("FAIL reset_enable: got %0b want 1", enable); else n_pass++;
        n_total++; if (plus !== 1'b0) $display("FAIL reset_plus: got %0b want 0", plus); else n_pass++;
        n_total++; if (minus !== 1'b0) $display("FAIL reset_minus: got %0b want 0", minus); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_m [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic       exp_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            press_mode_btn(10);
            n_total++;
            if (mode !== exp_m[i]) $display("FAIL mode_cycle_%0d: got %0b want %0b", i, mode, exp_m[i]);
            else n_pass++;
            n_total++;
            if (enable !== exp_e[i]) $display("FAIL enable_cycle_%0d: got %0b want %0b", i, enable, exp_e[i]);
            else n_pass++;
        end
        press_mode_btn(50);
        n_total++; if (mode !== 2'b01) $display("FAIL mode_hold50: got %0b want 01", mode); else n_pass++;
    endtask

    task automatic test_bounce();
        int np = 0;
        for (int c = 0; c < 30; c++) begin
            btn_plus = (c < 20) ? ((c / 2) % 2 == 0) : 1'b0;
            if (plus) np++;
            tick();
        end
        n_total++; if (np != 0) $display("FAIL bounce_plus: got %0d pulses want 0", np); else n_pass++;
        n_total++; if (mode !== 2'b01) $display("FAIL bounce_mode: got %0b want 01", mode); else n_pass++;
    endtask

    task automatic test_conflict();
        int np = 0;
        int nm = 0;
        for (int c = 0; c < 60; c++) begin
            btn_plus  = (c < 50);
            btn_minus = (c < 50);
            if (plus) np++;
            if (minus) nm++;
            tick();
        end
        n_total++; if (np != 0) $display("FAIL conflict_plus: got %0d pulses want 0", np); else n_pass++;
        n_total++; if (nm != 0) $display("FAIL conflict_minus: got %0d pulses want 0", nm); else n_pass++;
        n_total++; if (mode !== 2'b01) $display("FAIL conflict_mode: got %0b want 01", mode); else n_pass++;
    endtask

    task automatic test_clean_press();
        int pc[$];
        press_mode_btn(10);
        n_total++; if (mode !== 2'b10) $display("FAIL clean_mode: got %0b want 10", mode); else n_pass++;
        for (int c = 0; c < 32; c++) begin
            btn_plus = (c < 12);
            if (plus) pc.push_back(c);
            tick();
        end
        n_total++; if (pc.size() != 1) $display("FAIL clean_count: got %0d pulses want 1", pc.size()); else n_pass++;
        n_total++;
        if (pc.size() < 1 || pc[0] != 7) $display("FAIL clean_cycle: got %0d want 7", (pc.size() > 0) ? pc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_auto_repeat();
        int pc[$];
        int np = 0;
        int exp_c [5] = '{7, 27, 32, 37, 42};
        press_mode_btn(10);
        n_total++; if (mode !== 2'b11) $display("FAIL repeat_mode: got %0b want 11", mode); else n_pass++;
        for (int c = 0; c < 60; c++) begin
            btn_minus = (c < 40);
            if (minus) pc.push_back(c);
            if (plus) np++;
            tick();
        end
        n_total++; if (pc.size() != 5) $display("FAIL repeat_count: got %0d pulses want 5", pc.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (i >= pc.size() || pc[i] != exp_c[i])
                $display("FAIL repeat_cycle_%0d: got %0d want %0d", i, (i < pc.size()) ? pc[i] : -1, exp_c[i]);
            else n_pass++;
        end
        n_total++; if (np != 0) $display("FAIL repeat_no_plus: got %0d pulses want 0", np); else n_pass++;
    endtask

    task automatic test_gating_run();
        int np = 0;
        press_mode_btn(10);
        n_total++; if (mode !== 2'b00) $display("FAIL gate_mode: got %0b want 00", mode); else n_pass++;
        for (int c = 0; c < 30; c++) begin
            btn_plus = (c < 12);
            if (plus) np++;
            tick();
        end
        n_total++; if (np != 0) $display("FAIL gate_plus: got %0d pulses want 0", np); else n_pass++;
    endtask

    task automatic test_timeout();
        press_mode_btn(10);
        n_total++; if (mode !== 2'b01) $display("FAIL timeout_enter: got %0b want 01", mode); else n_pass++;
        repeat (80) tick();
        n_total++; if (mode !== 2'b01) $display("FAIL timeout_early: got %0b want 01", mode); else n_pass++;
        repeat (20) tick();
        n_total++; if (mode !== 2'b00) $display("FAIL timeout_mode: got %0b want 00", mode); else n_pass++;
        n_total++; if (enable !== 1'b1) $display("FAIL timeout_enable: got %0b want 1", enable); else n_pass++;
    endtask

    task automatic test_reset_midrepeat();
        int np = 0;
        press_mode_btn(10);
        for (int c = 0; c < 32; c++) begin
            btn_plus = 1'b1;
            if (plus) np++;
            if (c == 31) reset = 1'b1;
            tick();
        end
        n_total++; if (np != 2) $display("FAIL rst_pre_pulses: got %0d want 2", np); else n_pass++;
        n_total++; if (plus !== 1'b0) $display("FAIL rst_plus: got %0b want 0", plus); else n_pass++;
        n_total++; if (mode !== 2'b00) $display("FAIL rst_mode: got %0b want 00", mode); else n_pass++;
        n_total++; if (enable !== 1'b1) $display("FAIL rst_enable: got %0b want 1", enable); else n_pass++;
        reset = 1'b0;
        np = 0;
        for (int c = 0; c < 30; c++) begin
            if (plus) np++;
            tick();
        end
        n_total++; if (np != 0) $display("FAIL rst_held_plus: got %0d pulses want 0", np); else n_pass++;
        btn_plus = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_bounce();
        test_conflict();
        test_clean_press();
        test_auto_repeat();
        test_gating_run();
        test_timeout();
        test_reset_midrepeat();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
